led_mode_scheduler: RTL and testbench

//  Sequences the LED pattern mode and blink period fed to the LED driver chain and the period divider.

---
 rtl/led_pkg.sv | 44 ++++
 rtl/led_mode_scheduler_tick_gen.sv | 34 +++
 rtl/led_mode_scheduler.sv | 174 +++++++++++++++++
 tb/tb_led_mode_scheduler.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types, widths and helpers for the LED mode scheduler.
// Used by the scheduler top and its tick generator.
package led_pkg;

  localparam int NUM_MODES = 4;
  localparam int MODE_W    = 2;
  localparam int PERIOD_W  = 4;

  localparam logic [PERIOD_W-1:0] PERIOD_MIN = 4'd1;

  typedef enum logic [1:0] {
    MANUAL,
    AUTO_DWELL,
    AUTO_GAP
  } sched_state_t;

  function automatic logic [NUM_MODES-1:0] mode_onehot(
    input logic [MODE_W-1:0] idx
  );
    logic [NUM_MODES-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  function automatic logic [PERIOD_W-1:0] clamp_period(
    input logic [PERIOD_W-1:0] p
  );
    return (p == '0) ? PERIOD_MIN : p;
  endfunction

  // Lowest set key wins, so key0 has priority.
  function automatic logic [MODE_W-1:0] lowest_key(
    input logic [NUM_MODES-1:0] k
  );
    logic [MODE_W-1:0] r;
    r = '0;
    for (int i = NUM_MODES - 1; i >= 0; i--) begin
      if (k[i]) r = MODE_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/led_mode_scheduler_tick_gen.sv
// Divides the system clock down to a one-cycle tick strobe.
// The tick is high while the prescaler sits at its terminal count.
module tick_gen
  import led_pkg::*;
#(
  parameter int CLK_HZ  = 12_000_000,
  parameter int TICK_HZ = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Prescaler wraps 0..DIV-1.
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/led_mode_scheduler.sv
// LED mode scheduler: manual key selection or auto demo cycling.
// Optional AUTO_PERIOD_EN: auto mode ramps its own period code.
module led_mode_scheduler
  import led_pkg::*;
#(
  parameter int CLK_HZ  = 12_000_000,
  parameter int TICK_HZ = 1000,
  parameter int DWELL_T = 2000,
  parameter int GAP_T   = 200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_MODES-1:0] key_pulse,
  input  logic [PERIOD_W-1:0]  sw_period,
  input  logic                 auto_en,
  output logic [NUM_MODES-1:0] mode_sel,
  output logic [MODE_W-1:0]    mode_idx,
  output logic [PERIOD_W-1:0]  period,
  output logic                 mode_change,
  output logic                 cycle_done
);

  localparam int DW = $clog2(DWELL_T + 1);
  localparam int GW = (GAP_T > 0) ? $clog2(GAP_T + 1) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DWELL_T - 1);
  localparam logic [GW-1:0] GLAST = (GAP_T > 0) ? GW'(GAP_T - 1) : '0;

  logic tick;

  tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  sched_state_t         state_q, state_d;
  logic [MODE_W-1:0]    idx_q, idx_d;
  logic [NUM_MODES-1:0] sel_q, sel_d;
  logic [PERIOD_W-1:0]  per_q, per_d;
  logic [DW-1:0]        dwell_q, dwell_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 mc_q, mc_d;
  logic                 cd_q, cd_d;
  logic                 auto_prev_q;
  logic                 key_any;
  logic                 rise;
  logic                 adv;
`ifdef AUTO_PERIOD_EN
  logic [PERIOD_W-1:0]  aper_q, aper_d;
`endif

  assign key_any = |key_pulse;
  // auto_prev resets low so auto_en held through reset reads as a rise.
  assign rise    = auto_en & ~auto_prev_q;

  // Next-state, timers and registered-output values.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    gap_d   = gap_q;
    cd_d    = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      MANUAL: begin
        if (key_any) begin
          idx_d = lowest_key(key_pulse);
        end else if (rise) begin
          state_d = AUTO_DWELL;
          dwell_d = '0;
          gap_d   = '0;
        end
      end
      AUTO_DWELL, AUTO_GAP: begin
        if (key_any) begin
          state_d = MANUAL;
          idx_d   = lowest_key(key_pulse);
          dwell_d = '0;
          gap_d   = '0;
        end else if (!auto_en) begin
          state_d = MANUAL;
          dwell_d = '0;
          gap_d   = '0;
        end else if (tick) begin
          if (state_q == AUTO_DWELL) begin
            if (dwell_q == DLAST) begin
              dwell_d = '0;
              if (GAP_T > 0) state_d = AUTO_GAP;
              else           adv     = 1'b1;
            end else begin
              dwell_d = dwell_q + DW'(1);
            end
          end else begin
            if (gap_q == GLAST) begin
              gap_d   = '0;
              state_d = AUTO_DWELL;
              adv     = 1'b1;
            end else begin
              gap_d = gap_q + GW'(1);
            end
          end
        end
      end
      default: begin
        state_d = MANUAL;
      end
    endcase
    if (adv) begin
      idx_d = idx_q + MODE_W'(1);
      cd_d  = (idx_q == MODE_W'(NUM_MODES - 1));
    end
    mc_d  = (idx_d != idx_q);
    sel_d = (state_d == AUTO_GAP) ? '0 : mode_onehot(idx_d);
  end

`ifdef AUTO_PERIOD_EN
  // Auto period ramps 1..15 per completed cycle, restarting on auto entry.
  always_comb begin
    aper_d = aper_q;
    if (state_q == MANUAL && state_d != MANUAL) begin
      aper_d = PERIOD_MIN;
    end else if (cd_d) begin
      aper_d = (aper_q == '1) ? PERIOD_MIN : aper_q + PERIOD_W'(1);
    end
    per_d = (state_d == MANUAL) ? clamp_period(sw_period) : aper_d;
  end

  // Auto period register.
  always_ff @(posedge clk) begin
    if (rst) aper_q <= PERIOD_MIN;
    else     aper_q <= aper_d;
  end
`else
  // Period always follows the clamped switch code.
  always_comb begin
    per_d = clamp_period(sw_period);
  end
`endif

  // State, timers and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MANUAL;
      idx_q       <= '0;
      sel_q       <= mode_onehot('0);
      per_q       <= PERIOD_MIN;
      dwell_q     <= '0;
      gap_q       <= '0;
      mc_q        <= 1'b0;
      cd_q        <= 1'b0;
      auto_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sel_q       <= sel_d;
      per_q       <= per_d;
      dwell_q     <= dwell_d;
      gap_q       <= gap_d;
      mc_q        <= mc_d;
      cd_q        <= cd_d;
      auto_prev_q <= auto_en;
    end
  end

  assign mode_sel    = sel_q;
  assign mode_idx    = idx_q;
  assign period      = per_q;
  assign mode_change = mc_q;
  assign cycle_done  = cd_q;

endmodule

// File: tb/tb_led_mode_scheduler.sv
// Directed bench for led_mode_scheduler (tick every 10 clk, DWELL_T=3, GAP_T=1).
// Build with AUTO_PERIOD_EN defined to cover the auto period ramp.
module tb_led_mode_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_pulse;
  logic [3:0] sw_period;
  logic       auto_en;
  logic [3:0] mode_sel;
  logic [1:0] mode_idx;
  logic [3:0] period;
  logic       mode_change;
  logic       cycle_done;

  int total = 0;
  int bad   = 0;
  int ec    = 0;

  led_mode_scheduler #(
    .CLK_HZ  (1000),
    .TICK_HZ (100),
    .DWELL_T (3),
    .GAP_T   (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_pulse   (key_pulse),
    .sw_period   (sw_period),
    .auto_en     (auto_en),
    .mode_sel    (mode_sel),
    .mode_idx    (mode_idx),
    .period      (period),
    .mode_change (mode_change),
    .cycle_done  (cycle_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] key;
    logic [3:0] sw;
    logic [3:0] e_sel;
    logic [1:0] e_idx;
    logic [3:0] e_per;
    logic       e_mc;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, ec);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      ec++;
    end
  endtask

  task automatic step_to(input int target);
    if (target > ec) step(target - ec);
  endtask

  task automatic do_reset(input logic a, input logic [3:0] sw);
    rst       = 1'b1;
    key_pulse = '0;
    sw_period = sw;
    auto_en   = a;
    step(2);
    rst = 1'b0;
    ec  = 0;
  endtask

  task automatic chk_out(input string nm, input int sel, input int idx,
                         input int mc, input int cd);
    chk({nm, ".sel"}, int'(mode_sel), sel);
    chk({nm, ".idx"}, int'(mode_idx), idx);
    chk({nm, ".mc"}, int'(mode_change), mc);
    chk({nm, ".cd"}, int'(cycle_done), cd);
  endtask

  vec_t vt[9];

  initial begin
    // Manual-mode vectors: one clock per entry, outputs checked after it.
    vt[0] = '{4'b0000, 4'd0,  4'b0001, 2'd0, 4'd1,  1'b0};
    vt[1] = '{4'b0000, 4'd5,  4'b0001, 2'd0, 4'd5,  1'b0};
    vt[2] = '{4'b0110, 4'd5,  4'b0010, 2'd1, 4'd5,  1'b1};
    vt[3] = '{4'b0110, 4'd5,  4'b0010, 2'd1, 4'd5,  1'b0};
    vt[4] = '{4'b0000, 4'd5,  4'b0010, 2'd1, 4'd5,  1'b0};
    vt[5] = '{4'b1000, 4'd15, 4'b1000, 2'd3, 4'd15, 1'b1};
    vt[6] = '{4'b0000, 4'd0,  4'b1000, 2'd3, 4'd1,  1'b0};
    vt[7] = '{4'b1111, 4'd0,  4'b0001, 2'd0, 4'd1,  1'b1};
    vt[8] = '{4'b0100, 4'd9,  4'b0100, 2'd2, 4'd9,  1'b1};

    // Reset state.
    do_reset(1'b0, 4'd0);
    chk_out("reset", 4'b0001, 0, 0, 0);
    chk("reset.per", int'(period), 1);

    for (int i = 0; i < 9; i++) begin
      key_pulse = vt[i].key;
      sw_period = vt[i].sw;
      step(1);
      key_pulse = '0;
      chk($sformatf("vec%0d.sel", i), int'(mode_sel), int'(vt[i].e_sel));
      chk($sformatf("vec%0d.idx", i), int'(mode_idx), int'(vt[i].e_idx));
      chk($sformatf("vec%0d.per", i), int'(period), int'(vt[i].e_per));
      chk($sformatf("vec%0d.mc", i), int'(mode_change), int'(vt[i].e_mc));
      chk($sformatf("vec%0d.cd", i), int'(cycle_done), 0);
    end

    // Auto sequence; ticks land on edges 10, 20, 30, ...
    do_reset(1'b1, 4'd6);
    step_to(1);
    chk_out("auto.e1", 4'b0001, 0, 0, 0);
`ifdef AUTO_PERIOD_EN
    chk("auto.per1", int'(period), 1);
`else
    chk("auto.per1", int'(period), 6);
`endif
    step_to(29);
    chk_out("auto.e29", 4'b0001, 0, 0, 0);
    step_to(30);
    chk_out("auto.gap0", 4'b0000, 0, 0, 0);
    step_to(39);
    chk_out("auto.gap0end", 4'b0000, 0, 0, 0);
    step_to(40);
    chk_out("auto.m1", 4'b0010, 1, 1, 0);
    step_to(41);
    chk_out("auto.m1b", 4'b0010, 1, 0, 0);
    step_to(80);
    chk_out("auto.m2", 4'b0100, 2, 1, 0);
    step_to(120);
    chk_out("auto.m3", 4'b1000, 3, 1, 0);
    step_to(159);
    chk_out("auto.gap3", 4'b0000, 3, 0, 0);
    step_to(160);
    chk_out("auto.wrap", 4'b0001, 0, 1, 1);
`ifdef AUTO_PERIOD_EN
    chk("aper.2", int'(period), 2);
`endif
    step_to(161);
    chk_out("auto.wrapb", 4'b0001, 0, 0, 0);

`ifdef AUTO_PERIOD_EN
    step_to(320);
    chk("aper.3", int'(period), 3);
    step_to(2240);
    chk("aper.15", int'(period), 15);
    step_to(2400);
    chk("aper.wrap", int'(period), 1);
    chk("aper.cd", int'(cycle_done), 1);
    auto_en = 1'b0;
    step(1);
    chk("aper.manual", int'(period), 6);
    auto_en = 1'b1;
`endif

    // Key on the same cycle as dwell expiry beats the gap.
    do_reset(1'b1, 4'd2);
    step_to(29);
    key_pulse = 4'b1000;
    step(1);
    key_pulse = '0;
    chk_out("keyexp", 4'b1000, 3, 1, 0);
    chk("keyexp.per", int'(period), 2);
    step_to(60);
    chk_out("keyexp.stay", 4'b1000, 3, 0, 0);

    // auto_en dropped mid-gap restores mode_sel without a strobe.
    do_reset(1'b1, 4'd3);
    step_to(32);
    chk_out("drop.ingap", 4'b0000, 0, 0, 0);
    auto_en = 1'b0;
    step(1);
    chk_out("drop.manual", 4'b0001, 0, 0, 0);
    chk("drop.per", int'(period), 3);
    step_to(80);
    chk_out("drop.stay", 4'b0001, 0, 0, 0);

    // Reset mid-dwell of mode 1.
    do_reset(1'b1, 4'd7);
    step_to(45);
    chk_out("rstmid.pre", 4'b0010, 1, 0, 0);
    rst = 1'b1;
    auto_en = 1'b0;
    step(1);
    chk_out("rstmid", 4'b0001, 0, 0, 0);
    chk("rstmid.per", int'(period), 1);
    rst = 1'b0;
    step(1);
    chk("rstmid.per2", int'(period), 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
